pipe_hazard_unit: RTL and testbench
===================================

Name: pipe_hazard_unit

Overview:
Parametrised hazard and forwarding controller for the next-generation pipelined core. It tracks the destination register of every instruction in flight after decode, in a shift-register scoreboard of STAGES entries. It drives per-source forwarding selects and a load-use stall, and supports flushes and a hard-wired zero register. It replaces the ad-hoc single-stage forwarding muxes in the current core, generalising to any pipeline depth and register count.

Parameters:
ABITS, 3, register-number width; 2**ABITS architectural registers
STAGES, 3, tracked stages after decode: 1=EX, 2=MEM, STAGES=WB
LOAD_READY, 2, first stage whose output carries load data; range 1..STAGES
ZERO_REG, 0, 1 = register 0 reads as constant and is never forwarded or stalled on
CNTBITS, 16, width of the stall performance counter
SELW, clog2(STAGES+1), width of the forwarding selects (derived, not user-set)

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
id_valid  in  1  decode slot holds a real instruction
id_rs1, id_rs2  in  ABITS  source register numbers
id_rs1_used, id_rs2_used  in  1  source is actually read
id_wr  in  1  decode instruction writes a register
id_rd  in  ABITS  its destination register
id_load  in  1  decode instruction is a load
flush  in  1  squash the decode instruction this cycle (taken branch or jump)
fwd1_sel, fwd2_sel  out  SELW  0 = register file, k = result of stage k
stall  out  1  hold PC and decode; inject a bubble into stage 1
wb_we  out  1  stage STAGES entry valid and writing
wb_rd  out  ABITS  stage STAGES destination
stall_cnt  out  CNTBITS  saturating count of stall cycles

Behaviour:
- Each entry holds {valid, wr, rd, load}. Every cycle, entry k+1 <= entry k, for k = 1..STAGES-1.
- Stage 1 load rule:
  - on flush or stall, stage 1 gets a bubble (valid=0);
  - otherwise it gets {id_valid, id_wr, id_rd, id_load}.
- Match for each source s. A source is qualified only if id_valid, the used flag is set, and not (ZERO_REG and rs==0). If qualified, k = the smallest stage with valid & wr & rd==rs, so the youngest producer wins.
- Select and stall per source:
  - no match: sel=0;
  - match at an entry with load=1 and k<LOAD_READY: hazard;
  - otherwise sel=k.
- stall = (hazard on rs1 or rs2) and not flush. Flush dominates stall.
- While stall=1, both selects are driven to 0.
- Selects and stall are combinational from the current entries and the id_* inputs, with zero added latency.
- A stalled instruction re-evaluates the next cycle once the load has advanced. With the defaults, a load-use pair stalls exactly 1 cycle and then gets sel=2.
- The register file is not write-through, so a match at stage STAGES forwards the WB value.
- wb_we and wb_rd are taken directly from entry STAGES.
- stall_cnt increments on every cycle where stall=1 and saturates at all-ones.
- Reset (synchronous, active-high):
  - all entries are invalidated and stall_cnt=0 on the clock edge where reset=1;
  - outputs are then stall=0, sel=0, wb_we=0;
  - mid-operation reset discards all in-flight entries with no residual forwarding.
- Register-number width is ABITS throughout, with no truncation. A rd that matches with wr=0 must not forward.

Decomposition:
- Shared package:
  - forwarding-select encodings (FWD_RF=0);
  - stage index constants (STG_EX=1, STG_MEM=2);
  - the scoreboard-entry struct {valid, wr, rd, load}.
- One natural sub-module, hazard_match: a combinational priority search over the entries for a single source, returning the stage index and a load-hazard flag. It is instantiated twice.

Test Plan:
1. ADD writing r3, then next decode reads r3 on rs1 -> fwd1_sel=1, stall=0. The following cycle a reader of r3 on rs2 gets fwd2_sel=2.
2. LW writing r5, then next decode uses r5 on rs2 -> stall=1 for exactly 1 cycle and stall_cnt=1; the next cycle gives fwd2_sel=2, stall=0, and stage 1 holds a bubble.
3. Writers of r2 in consecutive cycles (stages 2 and 1 occupied), then a reader of r2 -> fwd1_sel=1 (youngest). With id_rs1_used=0 -> fwd1_sel=0.
4. ZERO_REG=1: writer of r0, then a reader of r0 -> sel=0, stall=0. ZERO_REG=0 with the same stimulus -> sel=1.
5. LW r4 followed by a load-use decode with flush=1 in the same cycle -> stall=0 and stall_cnt unchanged. The bubble reaches WB with wb_we=0 and the LW reaches WB with wb_we=1, wb_rd=4.
6. Pipeline fully occupied with writers of r1..r3, reset high for 1 cycle -> next cycle stall=0, all sels=0, wb_we=0, stall_cnt=0; a subsequent reader of r1 gets sel=0.

Source files
------------

// File: rtl/pipe_hazard_unit_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package pipe_hazard_unit_pkg;

  localparam int unsigned FWD_RF  = 0;
  localparam int unsigned STG_EX  = 1;
  localparam int unsigned STG_MEM = 2;

  // Register numbers are zero-extended into this field; wider ABITS is rejected at elaboration.
  localparam int unsigned RD_MAXW = 8;

  typedef struct packed {
    logic               valid;
    logic               wr;
    logic [RD_MAXW-1:0] rd;
    logic               load;
  } sb_entry_t;

endpackage

// File: rtl/pipe_hazard_unit_hazard_match.sv
// Priority search of the scoreboard for one source register: youngest producer wins.
module pipe_hazard_unit_hazard_match
  import pipe_hazard_unit_pkg::*;
#(
  parameter int unsigned ABITS      = 3,
  parameter int unsigned STAGES     = 3,
  parameter int unsigned LOAD_READY = 2,
  parameter int unsigned SELW       = 2
) (
  input  sb_entry_t [STAGES:1] entries,
  input  logic                 qual,
  input  logic [ABITS-1:0]     rs,
  output logic [SELW-1:0]      stage,
  output logic                 hazard
);

  always_comb begin
    stage  = '0;
    hazard = 1'b0;
    if (qual) begin
      // Walk oldest to youngest so the smallest matching stage is the last one written.
      for (int k = int'(STAGES); k >= 1; k--) begin
        if (entries[k].valid && entries[k].wr && (entries[k].rd == RD_MAXW'(rs))) begin
          stage  = SELW'(k);
          hazard = entries[k].load && (k < int'(LOAD_READY));
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Scoreboard-based hazard and forwarding controller: forwarding selects, load-use stall,
// flush bubbles and a saturating stall counter.
module pipe_hazard_unit
  import pipe_hazard_unit_pkg::*;
#(
  parameter int unsigned ABITS      = 3,
  parameter int unsigned STAGES     = 3,
  parameter int unsigned LOAD_READY = 2,
  parameter int unsigned ZERO_REG   = 0,
  parameter int unsigned CNTBITS    = 16,
  localparam int unsigned SELW      = $clog2(STAGES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [ABITS-1:0]   id_rs1,
  input  logic [ABITS-1:0]   id_rs2,
  input  logic               id_rs1_used,
  input  logic               id_rs2_used,
  input  logic               id_wr,
  input  logic [ABITS-1:0]   id_rd,
  input  logic               id_load,
  input  logic               flush,
  output logic [SELW-1:0]    fwd1_sel,
  output logic [SELW-1:0]    fwd2_sel,
  output logic               stall,
  output logic               wb_we,
  output logic [ABITS-1:0]   wb_rd,
  output logic [CNTBITS-1:0] stall_cnt
);

  if (ABITS > RD_MAXW || LOAD_READY < 1 || LOAD_READY > STAGES) begin : g_bad_params
    $error("pipe_hazard_unit: unsupported ABITS/LOAD_READY/STAGES combination");
  end

  localparam bit ZeroEn = (ZERO_REG != 0);

  sb_entry_t [STAGES:1] entry_q, entry_d;
  logic [CNTBITS-1:0]   cnt_q, cnt_d;

  logic            qual1, qual2;
  logic [SELW-1:0] stg1, stg2;
  logic            haz1, haz2;

  assign qual1 = id_valid && id_rs1_used && !(ZeroEn && (id_rs1 == '0));
  assign qual2 = id_valid && id_rs2_used && !(ZeroEn && (id_rs2 == '0));

  pipe_hazard_unit_hazard_match #(
    .ABITS      (ABITS),
    .STAGES     (STAGES),
    .LOAD_READY (LOAD_READY),
    .SELW       (SELW)
  ) u_match_rs1 (
    .entries (entry_q),
    .qual    (qual1),
    .rs      (id_rs1),
    .stage   (stg1),
    .hazard  (haz1)
  );

  pipe_hazard_unit_hazard_match #(
    .ABITS      (ABITS),
    .STAGES     (STAGES),
    .LOAD_READY (LOAD_READY),
    .SELW       (SELW)
  ) u_match_rs2 (
    .entries (entry_q),
    .qual    (qual2),
    .rs      (id_rs2),
    .stage   (stg2),
    .hazard  (haz2)
  );

  assign stall = (haz1 || haz2) && !flush;

  // A hazarded source never forwards, even when a flush suppresses the stall.
  assign fwd1_sel = (stall || haz1) ? SELW'(FWD_RF) : stg1;
  assign fwd2_sel = (stall || haz2) ? SELW'(FWD_RF) : stg2;

  assign wb_we     = entry_q[STAGES].valid && entry_q[STAGES].wr;
  assign wb_rd     = entry_q[STAGES].rd[ABITS-1:0];
  assign stall_cnt = cnt_q;

  always_comb begin
    entry_d         = entry_q;
    entry_d[STG_EX] = '0;
    if (!flush && !stall) begin
      entry_d[STG_EX].valid = id_valid;
      entry_d[STG_EX].wr    = id_wr;
      entry_d[STG_EX].rd    = RD_MAXW'(id_rd);
      entry_d[STG_EX].load  = id_load;
    end
    for (int k = int'(STG_MEM); k <= int'(STAGES); k++) begin
      entry_d[k] = entry_q[k-1];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNTBITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      entry_q <= '0;
      cnt_q   <= '0;
    end else begin
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench: directed vector table, hand sequences and randomized traffic
// against a history-queue reference model for two DUT configurations.
module tb_pipe_hazard_unit;

  localparam int STAGES     = 3;
  localparam int LOAD_READY = 2;
  localparam int CNT_MAX_A  = 65535;
  localparam int CNT_MAX_Z  = 7;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [2:0] id_rs1, id_rs2, id_rd;
  logic       id_rs1_used, id_rs2_used, id_wr, id_load, flush;

  logic [1:0]  a_fwd1, a_fwd2, z_fwd1, z_fwd2;
  logic        a_stall, a_wbwe, z_stall, z_wbwe;
  logic [2:0]  a_wbrd, z_wbrd;
  logic [15:0] a_cnt;
  logic [2:0]  z_cnt;

  always #5 clk = ~clk;

  pipe_hazard_unit dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_wr       (id_wr),
    .id_rd       (id_rd),
    .id_load     (id_load),
    .flush       (flush),
    .fwd1_sel    (a_fwd1),
    .fwd2_sel    (a_fwd2),
    .stall       (a_stall),
    .wb_we       (a_wbwe),
    .wb_rd       (a_wbrd),
    .stall_cnt   (a_cnt)
  );

  pipe_hazard_unit #(
    .ZERO_REG (1),
    .CNTBITS  (3)
  ) dut_z (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_wr       (id_wr),
    .id_rd       (id_rd),
    .id_load     (id_load),
    .flush       (flush),
    .fwd1_sel    (z_fwd1),
    .fwd2_sel    (z_fwd2),
    .stall       (z_stall),
    .wb_we       (z_wbwe),
    .wb_rd       (z_wbrd),
    .stall_cnt   (z_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: history of what entered stage 1, newest first; index i is stage i+1.
  typedef struct {
    bit valid;
    bit wr;
    int rd;
    bit load;
  } ment_t;

  ment_t hist_a[$];
  ment_t hist_z[$];
  int    cnt_a, cnt_z;

  function automatic void src_eval(input ment_t h[$], input bit zr, input int rs, input bit used,
                                   output int k, output bit haz);
    k   = 0;
    haz = 0;
    if (!id_valid || !used || (zr && rs == 0)) return;
    foreach (h[i]) begin
      if (h[i].valid && h[i].wr && h[i].rd == rs) begin
        k   = i + 1;
        haz = h[i].load && (k < LOAD_READY);
        return;
      end
    end
  endfunction

  function automatic void model_out(input ment_t h[$], input bit zr,
                                    output int s1, output int s2, output int st);
    int k1, k2;
    bit h1, h2;
    src_eval(h, zr, int'(id_rs1), id_rs1_used, k1, h1);
    src_eval(h, zr, int'(id_rs2), id_rs2_used, k2, h2);
    st = ((h1 || h2) && !flush) ? 1 : 0;
    s1 = (st != 0 || h1) ? 0 : k1;
    s2 = (st != 0 || h2) ? 0 : k2;
  endfunction

  task automatic check_dut(input string tag, input ment_t h[$], input bit zr, input int cnt,
                           input int a1, input int a2, input int ast, input int awe,
                           input int awrd, input int acnt);
    int s1, s2, st, we;
    model_out(h, zr, s1, s2, st);
    we = (h[STAGES-1].valid && h[STAGES-1].wr) ? 1 : 0;
    chk({tag, ".fwd1_sel"}, a1, s1);
    chk({tag, ".fwd2_sel"}, a2, s2);
    chk({tag, ".stall"}, ast, st);
    chk({tag, ".wb_we"}, awe, we);
    if (we != 0) chk({tag, ".wb_rd"}, awrd, h[STAGES-1].rd);
    chk({tag, ".stall_cnt"}, acnt, cnt);
  endtask

  task automatic model_reset();
    ment_t e;
    e = '{valid: 0, wr: 0, rd: 0, load: 0};
    hist_a.delete();
    hist_z.delete();
    for (int i = 0; i < STAGES; i++) begin
      hist_a.push_back(e);
      hist_z.push_back(e);
    end
    cnt_a = 0;
    cnt_z = 0;
  endtask

  task automatic model_update();
    ment_t e;
    int s1, s2, st;
    if (reset) begin
      model_reset();
      return;
    end
    e = '{valid: id_valid, wr: id_wr, rd: int'(id_rd), load: id_load};
    model_out(hist_a, 1'b0, s1, s2, st);
    hist_a.push_front((st != 0 || flush) ? '{valid: 0, wr: 0, rd: 0, load: 0} : e);
    void'(hist_a.pop_back());
    if (st != 0 && cnt_a < CNT_MAX_A) cnt_a++;
    model_out(hist_z, 1'b1, s1, s2, st);
    hist_z.push_front((st != 0 || flush) ? '{valid: 0, wr: 0, rd: 0, load: 0} : e);
    void'(hist_z.pop_back());
    if (st != 0 && cnt_z < CNT_MAX_Z) cnt_z++;
  endtask

  // Called at the falling edge: model check, then advance through the rising edge.
  task automatic finish_cycle();
    check_dut("dut", hist_a, 1'b0, cnt_a, int'(a_fwd1), int'(a_fwd2), int'(a_stall),
              int'(a_wbwe), int'(a_wbrd), int'(a_cnt));
    check_dut("dut_z", hist_z, 1'b1, cnt_z, int'(z_fwd1), int'(z_fwd2), int'(z_stall),
              int'(z_wbwe), int'(z_wbrd), int'(z_cnt));
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cycle();
    @(negedge clk);
    finish_cycle();
  endtask

  task automatic drive(input int v, input int rs1, input int u1, input int rs2, input int u2,
                       input int wr, input int rd, input int ld, input int fl);
    id_valid    = v[0];
    id_rs1      = rs1[2:0];
    id_rs1_used = u1[0];
    id_rs2      = rs2[2:0];
    id_rs2_used = u2[0];
    id_wr       = wr[0];
    id_rd       = rd[2:0];
    id_load     = ld[0];
    flush       = fl[0];
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    int v, rs1, u1, rs2, u2, wr, rd, ld, fl;
    int s1, s2, st, we, wrd, cnt;
  } vec_t;

  vec_t tab[17];

  initial begin
    //          v rs1 u1 rs2 u2 wr rd ld fl | s1 s2 st we wrd cnt
    tab[0]  = '{1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0};  // ADD r3
    tab[1]  = '{1, 3, 1, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0, 0};  // rs1=r3 from EX
    tab[2]  = '{1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0};  // rs2=r3 from MEM
    tab[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0};
    tab[4]  = '{1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0};  // LW r5
    tab[5]  = '{1, 0, 0, 5, 1, 1, 6, 0, 0, 0, 0, 1, 0, 0, 0};  // load-use stall
    tab[6]  = '{1, 0, 0, 5, 1, 1, 6, 0, 0, 0, 2, 0, 0, 0, 1};  // replay, sel=2
    tab[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 1};
    tab[8]  = '{1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1};  // stall bubble at WB
    tab[9]  = '{1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 1, 6, 1};
    tab[10] = '{1, 2, 1, 2, 0, 0, 2, 0, 0, 1, 0, 0, 0, 0, 1};  // youngest r2 wins
    tab[11] = '{1, 2, 0, 2, 1, 0, 0, 0, 0, 0, 2, 0, 1, 2, 1};  // rd match with wr=0 ignored
    tab[12] = '{1, 0, 0, 0, 0, 1, 4, 1, 0, 0, 0, 0, 1, 2, 1};  // LW r4
    tab[13] = '{1, 4, 1, 0, 0, 1, 7, 0, 1, 0, 0, 0, 0, 0, 1};  // flush beats stall
    tab[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    tab[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 1};  // LW r4 at WB
    tab[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};  // flush bubble at WB

    reset = 1'b1;
    nop();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("reset.stall", int'(a_stall), 0);
    chk("reset.fwd1", int'(a_fwd1), 0);
    chk("reset.wb_we", int'(a_wbwe), 0);
    chk("reset.cnt", int'(a_cnt), 0);
    finish_cycle();

    for (int i = 0; i < 17; i++) begin
      drive(tab[i].v, tab[i].rs1, tab[i].u1, tab[i].rs2, tab[i].u2, tab[i].wr, tab[i].rd,
            tab[i].ld, tab[i].fl);
      @(negedge clk);
      chk($sformatf("tab%0d.fwd1_sel", i), int'(a_fwd1), tab[i].s1);
      chk($sformatf("tab%0d.fwd2_sel", i), int'(a_fwd2), tab[i].s2);
      chk($sformatf("tab%0d.stall", i), int'(a_stall), tab[i].st);
      chk($sformatf("tab%0d.wb_we", i), int'(a_wbwe), tab[i].we);
      if (tab[i].we != 0) chk($sformatf("tab%0d.wb_rd", i), int'(a_wbrd), tab[i].wrd);
      chk($sformatf("tab%0d.stall_cnt", i), int'(a_cnt), tab[i].cnt);
      finish_cycle();
    end

    // Zero register: forwarded/stalled only when ZERO_REG=0
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0);
    cycle();
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("zero.dut.fwd1", int'(a_fwd1), 1);
    chk("zero.dut_z.fwd1", int'(z_fwd1), 0);
    chk("zero.dut_z.stall", int'(z_stall), 0);
    finish_cycle();
    drive(1, 0, 0, 0, 0, 1, 0, 1, 0);
    cycle();
    drive(1, 0, 0, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk("zero.dut.stall", int'(a_stall), 1);
    chk("zero.dut_z.stall", int'(z_stall), 0);
    finish_cycle();
    nop();
    repeat (3) cycle();

    // Mid-operation reset with a full pipeline
    for (int r = 1; r <= 3; r++) begin
      drive(1, 0, 0, 0, 0, 1, r, 0, 0);
      cycle();
    end
    nop();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    drive(1, 1, 1, 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst.stall", int'(a_stall), 0);
    chk("rst.fwd1", int'(a_fwd1), 0);
    chk("rst.fwd2", int'(a_fwd2), 0);
    chk("rst.wb_we", int'(a_wbwe), 0);
    chk("rst.cnt", int'(a_cnt), 0);
    finish_cycle();

    // Randomized traffic; stalled instructions are usually held in decode
    for (int n = 0; n < 3000; n++) begin
      int s1, s2, st;
      model_out(hist_a, 1'b0, s1, s2, st);
      if (!(st != 0 && $urandom_range(0, 3) != 0)) begin
        id_valid    = ($urandom_range(0, 7) != 0);
        id_rs1      = 3'($urandom_range(0, 7));
        id_rs2      = 3'($urandom_range(0, 7));
        id_rs1_used = ($urandom_range(0, 3) != 0);
        id_rs2_used = ($urandom_range(0, 1) != 0);
        id_wr       = ($urandom_range(0, 3) != 0);
        id_rd       = 3'($urandom_range(0, 7));
        id_load     = id_wr && ($urandom_range(0, 1) != 0);
      end
      flush = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 199) == 0);
      cycle();
    end
    reset = 1'b0;
    nop();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
